mano_io_unit: RTL

Byte-wide I/O unit for the MANO computer. It owns the INPR register and the FGI/FGO flags, and sits between external character devices and the control path. Two DEPTH-entry FIFOs decouple the devices from instruction timing. Incoming bytes are presented to the CPU one at a time through INPR/FGI. Bytes written by the OUT instruction are queued and drained to the output device over a valid/ready handshake.

---
 rtl/mano_io_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mano_io_unit.sv
// MANO computer byte I/O unit: input FIFO feeding INPR/FGI, OUT bytes queued
// through an output FIFO and drained to the device over valid/ready.
module mano_io_unit #(
  parameter int DEPTH = 4
) (
  input  logic       mclk,
  input  logic       mrst,
  input  logic [7:0] dev_in_data,
  input  logic       dev_in_valid,
  output logic       dev_in_ready,
  output logic [7:0] dev_out_data,
  output logic       dev_out_valid,
  input  logic       dev_out_ready,
  input  logic       cs_fgi_clr,
  input  logic       cs_fgo_clr,
  input  logic [7:0] out_byte,
  input  logic       ien,
  output logic [7:0] inpr,
  output logic       fgi,
  output logic       fgo,
  output logic       io_irq,
  output logic       out_drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    in_mem  [DEPTH];
  logic [7:0]    out_mem [DEPTH];

  logic [AW-1:0] in_rd_q, in_rd_d, in_wr_q, in_wr_d;
  logic [AW-1:0] out_rd_q, out_rd_d, out_wr_q, out_wr_d;
  logic [AW:0]   in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [7:0]    inpr_q, inpr_d;
  logic          fgi_q, fgi_d, fgo_q, fgo_d, drop_q, drop_d;

  logic in_full, in_empty, out_full, out_empty;
  logic in_push, in_pop, out_push, out_pop;

  assign in_full   = (in_cnt_q == FULL_CNT);
  assign in_empty  = (in_cnt_q == '0);
  assign out_full  = (out_cnt_q == FULL_CNT);
  assign out_empty = (out_cnt_q == '0);

  assign in_push  = dev_in_valid & ~in_full;
  // INPR reloads only while the registered flag is clear, so an INP never
  // overlaps a reload in the same cycle.
  assign in_pop   = ~fgi_q & ~in_empty;
  assign out_pop  = ~out_empty & dev_out_ready;
  assign out_push = cs_fgo_clr & fgo_q & (~out_full | out_pop);

  always_comb begin
    in_rd_d   = in_rd_q;
    in_wr_d   = in_wr_q;
    in_cnt_d  = in_cnt_q;
    out_rd_d  = out_rd_q;
    out_wr_d  = out_wr_q;
    out_cnt_d = out_cnt_q;
    inpr_d    = inpr_q;
    fgi_d     = fgi_q;
    fgo_d     = fgo_q;
    drop_d    = drop_q;

    if (in_push) in_wr_d = in_wr_q + PTR_ONE;
    if (in_pop)  in_rd_d = in_rd_q + PTR_ONE;
    case ({in_push, in_pop})
      2'b10:   in_cnt_d = in_cnt_q + CNT_ONE;
      2'b01:   in_cnt_d = in_cnt_q - CNT_ONE;
      default: in_cnt_d = in_cnt_q;
    endcase

    if (out_push) out_wr_d = out_wr_q + PTR_ONE;
    if (out_pop)  out_rd_d = out_rd_q + PTR_ONE;
    case ({out_push, out_pop})
      2'b10:   out_cnt_d = out_cnt_q + CNT_ONE;
      2'b01:   out_cnt_d = out_cnt_q - CNT_ONE;
      default: out_cnt_d = out_cnt_q;
    endcase

    if (in_pop) begin
      inpr_d = in_mem[in_rd_q];
      fgi_d  = 1'b1;
    end else if (cs_fgi_clr && fgi_q) begin
      fgi_d  = 1'b0;
    end

    // Re-arm looks at the registered count, so fgo is low at least one cycle.
    if (cs_fgo_clr && fgo_q)            fgo_d = 1'b0;
    else if (!fgo_q && !out_full)       fgo_d = 1'b1;

    if (cs_fgo_clr && !fgo_q) drop_d = 1'b1;
  end

  always_ff @(posedge mclk or negedge mrst) begin
    if (!mrst) begin
      in_rd_q   <= '0;
      in_wr_q   <= '0;
      in_cnt_q  <= '0;
      out_rd_q  <= '0;
      out_wr_q  <= '0;
      out_cnt_q <= '0;
      inpr_q    <= 8'h00;
      fgi_q     <= 1'b0;
      fgo_q     <= 1'b1;
      drop_q    <= 1'b0;
    end else begin
      in_rd_q   <= in_rd_d;
      in_wr_q   <= in_wr_d;
      in_cnt_q  <= in_cnt_d;
      out_rd_q  <= out_rd_d;
      out_wr_q  <= out_wr_d;
      out_cnt_q <= out_cnt_d;
      inpr_q    <= inpr_d;
      fgi_q     <= fgi_d;
      fgo_q     <= fgo_d;
      drop_q    <= drop_d;
    end
  end

  // Storage needs no reset: pointers and counts define which entries are live.
  always_ff @(posedge mclk) begin
    if (in_push)  in_mem[in_wr_q]   <= dev_in_data;
    if (out_push) out_mem[out_wr_q] <= out_byte;
  end

  assign dev_in_ready  = ~in_full;
  assign dev_out_valid = ~out_empty;
  assign dev_out_data  = out_empty ? 8'h00 : out_mem[out_rd_q];
  assign inpr          = inpr_q;
  assign fgi           = fgi_q;
  assign fgo           = fgo_q;
  assign out_drop      = drop_q;
  assign io_irq        = ien & (fgi_q | fgo_q);

endmodule
